// File: rtl/sram_stage_sequencer_pkg.sv
// Shared definitions for the SRAM stage sequencer: state encoding, default
// stage indices and a small elaboration-time helper.
package sram_stage_sequencer_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_LAUNCH = 2'd1;
   localparam logic [1:0] ST_RUN    = 2'd2;
   localparam logic [1:0] ST_ERROR  = 2'd3;

   typedef enum logic [1:0] {
      StIdle   = ST_IDLE,
      StLaunch = ST_LAUNCH,
      StRun    = ST_RUN,
      StError  = ST_ERROR
   } state_e;

   // Stage slots of the original fixed three-stage datapath.
   localparam int unsigned SEL_UPSAMPLE   = 0;
   localparam int unsigned SEL_CONVERSION = 1;
   localparam int unsigned SEL_VGA        = 2;

   // Index width needed to address 'value' stages (at least 1 bit).
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned res;
      res = 1;
      for (int i = 1; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) res = i + 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/sram_stage_sequencer_stage_mask_scan.sv
// Combinational scan of a stage mask: lowest enabled stage and the next
// enabled stage strictly above the current index.
module sram_stage_sequencer_stage_mask_scan
   import sram_stage_sequencer_pkg::*;
#(
   parameter int unsigned N_STAGES = 3,
   parameter int unsigned SEL_W    = 4
) (
   input  logic [N_STAGES-1:0] mask_i,
   input  logic [SEL_W-1:0]    cur_i,
   output logic [SEL_W-1:0]    lowest_o,
   output logic [SEL_W-1:0]    next_o,
   output logic                has_next_o
);

   // Walk from the top down so the last hit is the lowest qualifying bit.
   always_comb begin
      lowest_o   = '0;
      next_o     = '0;
      has_next_o = 1'b0;
      for (int i = int'(N_STAGES) - 1; i >= 0; i--) begin
         if (mask_i[i]) begin
            lowest_o = SEL_W'(i);
            if (i > int'(cur_i)) begin
               next_o     = SEL_W'(i);
               has_next_o = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/sram_stage_sequencer.sv
// Sequences up to N_STAGES client engines over one shared SRAM port, with
// per-run stage masking, frame-loop mode, a per-stage watchdog and abort.
module sram_stage_sequencer
   import sram_stage_sequencer_pkg::*;
#(
   parameter int unsigned AW             = 18,
   parameter int unsigned DW             = 16,
   parameter int unsigned N_STAGES       = 3,
   parameter int unsigned SEL_W          = 4,
   parameter int unsigned TIMEOUT_CYCLES = 0,
   parameter int unsigned WD_W           = 24
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   abort,
   input  logic [N_STAGES-1:0]    stage_mask,
   input  logic                   continuous,
   output logic                   busy,
   output logic                   done,
   output logic                   error,
   output logic [SEL_W-1:0]       cur_stage,
   output logic [N_STAGES-1:0]    stg_start,
   input  logic [N_STAGES-1:0]    stg_done,
   input  logic [N_STAGES*AW-1:0] stg_raddr,
   input  logic [N_STAGES*AW-1:0] stg_waddr,
   input  logic [N_STAGES*DW-1:0] stg_wdata,
   input  logic [N_STAGES-1:0]    stg_wr_enable,
   output logic [DW-1:0]          stg_rdata,
   output logic [AW-1:0]          sram_raddr,
   input  logic [DW-1:0]          sram_rdata,
   output logic [AW-1:0]          sram_waddr,
   output logic [DW-1:0]          sram_wdata,
   output logic                   sram_wr_enable
);

   state_e              state_q, state_d;
   logic [SEL_W-1:0]    cur_q, cur_d;
   logic [N_STAGES-1:0] mask_q, mask_d;
   logic                cont_q, cont_d;
   logic [WD_W-1:0]     wd_q, wd_d;
   logic                done_q, done_d;
   logic                err_q, err_d;

   logic [N_STAGES-1:0] scan_mask;
   logic [SEL_W-1:0]    scan_lowest, scan_next;
   logic                scan_has_next;
   logic                owner_done;
   logic                owns_port;

   // In IDLE the incoming mask picks the first stage; otherwise the latched one.
   assign scan_mask = (state_q == StIdle) ? stage_mask : mask_q;

   sram_stage_sequencer_stage_mask_scan #(
      .N_STAGES (N_STAGES),
      .SEL_W    (SEL_W)
   ) u_scan (
      .mask_i     (scan_mask),
      .cur_i      (cur_q),
      .lowest_o   (scan_lowest),
      .next_o     (scan_next),
      .has_next_o (scan_has_next)
   );

   assign owns_port = (state_q == StLaunch) || (state_q == StRun);
   assign busy      = owns_port;
   assign done      = done_q;
   assign error     = err_q;
   assign cur_stage = cur_q;
   assign stg_rdata = sram_rdata;

   // Owner's done and the one-hot launch pulse, both decoded from cur_q.
   always_comb begin
      owner_done = 1'b0;
      stg_start  = '0;
      for (int i = 0; i < int'(N_STAGES); i++) begin
         if (SEL_W'(i) == cur_q) begin
            owner_done   = stg_done[i];
            stg_start[i] = (state_q == StLaunch);
         end
      end
   end

   // Zero-latency port mux; the port is parked at zero unless a stage owns it.
   always_comb begin
      sram_raddr     = '0;
      sram_waddr     = '0;
      sram_wdata     = '0;
      sram_wr_enable = 1'b0;
      if (owns_port) begin
         for (int i = 0; i < int'(N_STAGES); i++) begin
            if (SEL_W'(i) == cur_q) begin
               sram_raddr     = stg_raddr[i*AW +: AW];
               sram_waddr     = stg_waddr[i*AW +: AW];
               sram_wdata     = stg_wdata[i*DW +: DW];
               sram_wr_enable = stg_wr_enable[i];
            end
         end
      end
   end

   // Next-state logic; abort overrides everything else in the same cycle.
   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      mask_d  = mask_q;
      cont_d  = cont_q;
      wd_d    = wd_q;
      done_d  = 1'b0;
      err_d   = err_q;
      if (abort) begin
         state_d = StIdle;
         err_d   = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  if (|stage_mask) begin
                     mask_d  = stage_mask;
                     cont_d  = continuous;
                     cur_d   = scan_lowest;
                     state_d = StLaunch;
                  end else begin
                     done_d = 1'b1;
                  end
               end
            end
            StLaunch: begin
               wd_d    = '0;
               state_d = StRun;
            end
            StRun: begin
               if (owner_done) begin
                  if (scan_has_next) begin
                     cur_d   = scan_next;
                     state_d = StLaunch;
                  end else begin
                     done_d = 1'b1;
                     if (cont_q) begin
                        cur_d   = scan_lowest;
                        state_d = StLaunch;
                     end else begin
                        state_d = StIdle;
                     end
                  end
               end else if ((TIMEOUT_CYCLES != 0) &&
                            (wd_q == WD_W'(TIMEOUT_CYCLES - 1))) begin
                  state_d = StError;
                  err_d   = 1'b1;
               end else begin
                  wd_d = wd_q + WD_W'(1);
               end
            end
            StError: begin
               err_d = 1'b1;
            end
         endcase
      end
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cur_q   <= '0;
         mask_q  <= '0;
         cont_q  <= 1'b0;
         wd_q    <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         mask_q  <= mask_d;
         cont_q  <= cont_d;
         wd_q    <= wd_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_sram_stage_sequencer.sv
// Scoreboard bench for sram_stage_sequencer: stimulus pushes expected
// start/done events, a monitor pops and compares them as the DUT emits them.
module tb_sram_stage_sequencer;

   localparam int AW = 18;
   localparam int DW = 16;
   localparam int N  = 3;
   localparam int SW = 4;
   localparam int TO = 8;
   localparam int WW = 24;

   typedef struct packed {
      logic          done;
      logic [N-1:0]  start;
      logic          busy;
      logic [SW-1:0] cur;
   } ev_t;

   logic            clk;
   logic            reset, start, abort, continuous;
   logic [N-1:0]    stage_mask;
   logic            busy, done, error;
   logic [SW-1:0]   cur_stage;
   logic [N-1:0]    stg_start, stg_done, resp_done, inj_done, we;
   logic [N*AW-1:0] stg_raddr, stg_waddr;
   logic [N*DW-1:0] stg_wdata;
   logic [DW-1:0]   stg_rdata, sram_rdata, sram_wdata;
   logic [AW-1:0]   sram_raddr, sram_waddr;
   logic            sram_wr_enable;

   ev_t exp_q[$];
   int  checks = 0;
   int  passes = 0;
   int  dly[N];
   int  cnt[N];

   assign stg_done = resp_done | inj_done;

   for (genvar g = 0; g < N; g++) begin : g_stage_bus
      assign stg_raddr[g*AW +: AW] = AW'(32'h100 + g);
      assign stg_waddr[g*AW +: AW] = AW'(32'h3000 + 16 * g);
      assign stg_wdata[g*DW +: DW] = DW'(32'hA000 + g);
   end

   sram_stage_sequencer #(
      .AW             (AW),
      .DW             (DW),
      .N_STAGES       (N),
      .SEL_W          (SW),
      .TIMEOUT_CYCLES (TO),
      .WD_W           (WW)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .abort          (abort),
      .stage_mask     (stage_mask),
      .continuous     (continuous),
      .busy           (busy),
      .done           (done),
      .error          (error),
      .cur_stage      (cur_stage),
      .stg_start      (stg_start),
      .stg_done       (stg_done),
      .stg_raddr      (stg_raddr),
      .stg_waddr      (stg_waddr),
      .stg_wdata      (stg_wdata),
      .stg_wr_enable  (we),
      .stg_rdata      (stg_rdata),
      .sram_raddr     (sram_raddr),
      .sram_rdata     (sram_rdata),
      .sram_waddr     (sram_waddr),
      .sram_wdata     (sram_wdata),
      .sram_wr_enable (sram_wr_enable)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: got %0h, required %0h", name, act, req);
   endtask

   function automatic ev_t mk(input logic d, input logic [N-1:0] s, input logic b,
                              input logic [SW-1:0] c);
      ev_t e;
      e.done  = d;
      e.start = s;
      e.busy  = b;
      e.cur   = c;
      return e;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_run(input logic [N-1:0] m, input logic c);
      stage_mask = m;
      continuous = c;
      start      = 1'b1;
      step();
      start      = 1'b0;
      stage_mask = ~m;   // must not be re-sampled mid-run
      continuous = ~c;
   endtask

   task automatic wait_drain(input string name, input int max_cycles);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < max_cycles) begin
         step();
         n++;
      end
      check(name, 64'(exp_q.size()), 64'd0);
   endtask

   // Stage model: done pulses dly[i] cycles after its start (dly 0 = never).
   initial begin
      resp_done = '0;
      for (int i = 0; i < N; i++) cnt[i] = 0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            resp_done[i] = 1'b0;
            if (cnt[i] > 0) begin
               cnt[i]--;
               if (cnt[i] == 0) resp_done[i] = 1'b1;
            end
            if (stg_start[i] && dly[i] > 0) cnt[i] = dly[i];
         end
      end
   end

   // Monitor: every start or done pulse must match the head of the queue.
   initial begin
      ev_t e;
      forever begin
         @(negedge clk);
         if (!reset && (stg_start != '0 || done)) begin
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_event: got start=%b done=%b, required no event",
                        stg_start, done);
            end else begin
               e = exp_q.pop_front();
               check("ev_start", 64'(stg_start), 64'(e.start));
               check("ev_done", 64'(done), 64'(e.done));
               check("ev_busy", 64'(busy), 64'(e.busy));
               if (e.start != '0) begin
                  check("ev_cur", 64'(cur_stage), 64'(e.cur));
                  check("mux_raddr", 64'(sram_raddr), 64'(32'h100 + 32'(e.cur)));
                  check("mux_waddr", 64'(sram_waddr), 64'(32'h3000 + 16 * 32'(e.cur)));
                  check("mux_wdata", 64'(sram_wdata), 64'(32'hA000 + 32'(e.cur)));
                  check("mux_wr_en", 64'(sram_wr_enable), 64'(we[e.cur[1:0]]));
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, required finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0; stage_mask = '0; continuous = 1'b0;
      we = 3'b111; sram_rdata = 16'h5A5A; inj_done = '0;
      for (int i = 0; i < N; i++) dly[i] = 5;
      repeat (3) step();
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_error", 64'(error), 64'd0);
      check("rst_stg_start", 64'(stg_start), 64'd0);
      check("rst_cur", 64'(cur_stage), 64'd0);
      check("rst_sram_we", 64'(sram_wr_enable), 64'd0);
      check("rst_sram_raddr", 64'(sram_raddr), 64'd0);
      check("rdata_bcast", 64'(stg_rdata), 64'h5A5A);
      reset = 1'b0;
      step();

      // All three stages in order; a start mid-run is ignored.
      exp_q.push_back(mk(1'b0, 3'b001, 1'b1, 4'd0));
      exp_q.push_back(mk(1'b0, 3'b010, 1'b1, 4'd1));
      exp_q.push_back(mk(1'b0, 3'b100, 1'b1, 4'd2));
      exp_q.push_back(mk(1'b1, 3'b000, 1'b0, 4'd0));
      start_run(3'b111, 1'b0);
      repeat (3) step();
      stage_mask = 3'b001; start = 1'b1;
      step();
      start = 1'b0;
      wait_drain("drain_all3", 100);
      check("idle_busy_t1", 64'(busy), 64'd0);

      // Stage 1 masked out; its write enable never reaches the port.
      we = 3'b010;
      exp_q.push_back(mk(1'b0, 3'b001, 1'b1, 4'd0));
      exp_q.push_back(mk(1'b0, 3'b100, 1'b1, 4'd2));
      exp_q.push_back(mk(1'b1, 3'b000, 1'b0, 4'd0));
      start_run(3'b101, 1'b0);
      repeat (3) step();
      check("skip_we_mid", 64'(sram_wr_enable), 64'd0);
      check("skip_raddr_mid", 64'(sram_raddr), 64'h100);
      wait_drain("drain_skip", 100);

      // Continuous mode: done coincides with the next pass's first start; then abort.
      we = 3'b111;
      exp_q.push_back(mk(1'b0, 3'b001, 1'b1, 4'd0));
      exp_q.push_back(mk(1'b0, 3'b010, 1'b1, 4'd1));
      exp_q.push_back(mk(1'b1, 3'b001, 1'b1, 4'd0));
      exp_q.push_back(mk(1'b0, 3'b010, 1'b1, 4'd1));
      exp_q.push_back(mk(1'b1, 3'b001, 1'b1, 4'd0));
      start_run(3'b011, 1'b1);
      wait_drain("drain_cont", 100);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_we", 64'(sram_wr_enable), 64'd0);
      check("abort_stg_start", 64'(stg_start), 64'd0);
      repeat (20) step();
      check("abort_stays_idle", 64'(busy), 64'd0);

      // Watchdog boundary: done in the last allowed RUN cycle wins.
      dly[0] = 8;
      exp_q.push_back(mk(1'b0, 3'b001, 1'b1, 4'd0));
      exp_q.push_back(mk(1'b1, 3'b000, 1'b0, 4'd0));
      start_run(3'b001, 1'b0);
      wait_drain("drain_wd_edge", 50);
      check("wd_edge_error", 64'(error), 64'd0);

      // Watchdog expiry: stage 0 never finishes.
      dly[0] = 0;
      exp_q.push_back(mk(1'b0, 3'b001, 1'b1, 4'd0));
      start_run(3'b001, 1'b0);
      repeat (8) step();
      check("wd_pre_error", 64'(error), 64'd0);
      check("wd_pre_busy", 64'(busy), 64'd1);
      step();
      check("wd_error", 64'(error), 64'd1);
      check("wd_busy", 64'(busy), 64'd0);
      check("wd_sram_we", 64'(sram_wr_enable), 64'd0);
      check("wd_sram_raddr", 64'(sram_raddr), 64'd0);
      check("wd_sram_wdata", 64'(sram_wdata), 64'd0);
      start_run(3'b111, 1'b0);
      step();
      check("err_start_ignored", 64'(error), 64'd1);
      check("err_start_busy", 64'(busy), 64'd0);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("err_abort_clear", 64'(error), 64'd0);
      step();

      // Empty mask: done pulse only.
      exp_q.push_back(mk(1'b1, 3'b000, 1'b0, 4'd0));
      start_run(3'b000, 1'b0);
      wait_drain("drain_empty", 5);

      // Non-owner done is ignored.
      dly[1] = 5;
      exp_q.push_back(mk(1'b0, 3'b001, 1'b1, 4'd0));
      exp_q.push_back(mk(1'b0, 3'b010, 1'b1, 4'd1));
      exp_q.push_back(mk(1'b1, 3'b000, 1'b0, 4'd0));
      start_run(3'b011, 1'b0);
      step();
      inj_done = 3'b010;
      step();
      inj_done = '0;
      repeat (2) step();
      check("nonowner_busy", 64'(busy), 64'd1);
      check("nonowner_cur", 64'(cur_stage), 64'd0);
      inj_done = 3'b001;
      step();
      inj_done = '0;
      wait_drain("drain_nonowner", 50);

      // Reset mid-RUN, then a clean re-run from the lowest enabled stage.
      for (int i = 0; i < N; i++) dly[i] = 5;
      exp_q.push_back(mk(1'b0, 3'b010, 1'b1, 4'd1));
      start_run(3'b110, 1'b0);
      repeat (2) step();
      reset = 1'b1;
      step();
      check("mrst_busy", 64'(busy), 64'd0);
      check("mrst_cur", 64'(cur_stage), 64'd0);
      check("mrst_stg_start", 64'(stg_start), 64'd0);
      check("mrst_sram_we", 64'(sram_wr_enable), 64'd0);
      check("mrst_sram_waddr", 64'(sram_waddr), 64'd0);
      reset = 1'b0;
      repeat (12) step();
      exp_q.push_back(mk(1'b0, 3'b010, 1'b1, 4'd1));
      exp_q.push_back(mk(1'b0, 3'b100, 1'b1, 4'd2));
      exp_q.push_back(mk(1'b1, 3'b000, 1'b0, 4'd0));
      start_run(3'b110, 1'b0);
      wait_drain("drain_rerun", 100);
      repeat (10) step();
      check("final_busy", 64'(busy), 64'd0);
      check("final_queue", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
